vga_sync_monitor: RTL and testbench

//  Receive-side companion of the VGA colour/timing generator. Samples VGA_HSYNC, VGA_VSYNC and
//  4-bit RGB, recovers pixel coordinates and measures line/frame timing. Locks to a frame and flags

---
 rtl/vga_sync_monitor.sv | 237 +++++++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: receive-side VGA timing monitor. Recovers the active pixel
// coordinate from HSYNC/VSYNC, measures line and frame length, locks to the
// frame timing, flags sticky timing errors and captures the colour at a
// programmable active coordinate.
module vga_sync_monitor #(
   parameter int unsigned H_SYNC  = 96,
   parameter int unsigned H_BP    = 48,
   parameter int unsigned H_ACT   = 640,
   parameter int unsigned H_TOTAL = 800,
   parameter int unsigned V_SYNC  = 2,
   parameter int unsigned V_BP    = 33,
   parameter int unsigned V_ACT   = 480,
   parameter int unsigned V_TOTAL = 525
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        PIX_CE,
   input  logic        VGA_HSYNC,
   input  logic        VGA_VSYNC,
   input  logic [3:0]  VGA_RED,
   input  logic [3:0]  VGA_GREEN,
   input  logic [3:0]  VGA_BLUE,
   input  logic [10:0] CAP_X,
   input  logic [10:0] CAP_Y,
   input  logic        ERR_CLR,
   output logic [10:0] PIX_X,
   output logic [10:0] PIX_Y,
   output logic        PIX_VALID,
   output logic [11:0] PIX_RGB,
   output logic [10:0] LINE_LEN,
   output logic [10:0] FRAME_LINES,
   output logic        FRAME_DONE,
   output logic        LOCKED,
   output logic        H_ERR,
   output logic        V_ERR,
   output logic [11:0] CAP_RGB,
   output logic        CAP_VALID
);

   localparam logic [10:0] H_START   = 11'(H_SYNC + H_BP);
   localparam logic [10:0] H_END     = 11'(H_SYNC + H_BP + H_ACT - 1);
   localparam logic [10:0] V_START   = 11'(V_SYNC + V_BP);
   localparam logic [10:0] V_END     = 11'(V_SYNC + V_BP + V_ACT - 1);
   localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
   localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
   localparam logic [10:0] V_SYNC_W  = 11'(V_SYNC);
   localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
   localparam logic [10:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_ALIGN  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        hs_q, hs_d, hs_prev_q, hs_prev_d;
   logic        vs_q, vs_d, vs_prev_q, vs_prev_d;
   logic [11:0] rgb_q, rgb_d, rgb_dly_q, rgb_dly_d;
   logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [10:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
   logic        frame_done_q, frame_done_d;
   logic        h_err_q, h_err_d, v_err_q, v_err_d;
   logic [10:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic        pix_valid_q, pix_valid_d;
   logic [11:0] pix_rgb_q, pix_rgb_d;
   logic [11:0] cap_rgb_q, cap_rgb_d;
   logic        cap_valid_q, cap_valid_d;

   logic        hs_fall, hs_rise, vs_fall, vs_rise;
   logic [10:0] h_inc, v_inc;
   logic        h_new, v_new, in_win;

   assign hs_fall = hs_prev_q & ~hs_q;
   assign hs_rise = ~hs_prev_q & hs_q;
   assign vs_fall = vs_prev_q & ~vs_q;
   assign vs_rise = ~vs_prev_q & vs_q;
   assign h_inc   = (h_cnt_q == CNT_MAX) ? CNT_MAX : h_cnt_q + 11'd1;
   assign v_inc   = (v_cnt_q == CNT_MAX) ? CNT_MAX : v_cnt_q + 11'd1;

   // Sample pins, advance coordinate counters and record line/frame lengths
   always_comb begin
      hs_d          = hs_q;
      hs_prev_d     = hs_prev_q;
      vs_d          = vs_q;
      vs_prev_d     = vs_prev_q;
      rgb_d         = rgb_q;
      rgb_dly_d     = rgb_dly_q;
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      line_len_d    = line_len_q;
      frame_lines_d = frame_lines_q;
      frame_done_d  = 1'b0;
      if (PIX_CE) begin
         hs_d      = VGA_HSYNC;
         hs_prev_d = hs_q;
         vs_d      = VGA_VSYNC;
         vs_prev_d = vs_q;
         rgb_d     = {VGA_RED, VGA_GREEN, VGA_BLUE};
         // colour delayed one sample so it lines up with the counters
         rgb_dly_d = rgb_q;
         h_cnt_d   = hs_fall ? '0 : h_inc;
         if (hs_fall) begin
            line_len_d = h_inc;
         end
         if (vs_fall) begin
            v_cnt_d       = '0;
            frame_lines_d = v_inc;
         end else if (hs_fall) begin
            v_cnt_d = v_inc;
         end
         frame_done_d = vs_fall;
      end
   end

   // Timing checks while aligning or locked; sticky flags where a new error beats a clear
   always_comb begin
      h_new = 1'b0;
      v_new = 1'b0;
      if (PIX_CE && (state_q != ST_SEARCH)) begin
         h_new = (hs_rise && (h_inc != H_SYNC_W)) ||
                 (hs_fall && (h_inc != H_TOTAL_W)) ||
                 (!hs_fall && (h_inc == CNT_MAX));
         v_new = (vs_rise && (v_cnt_d != V_SYNC_W)) ||
                 (vs_fall && (v_inc != V_TOTAL_W));
      end
      h_err_d = h_err_q;
      v_err_d = v_err_q;
      if (ERR_CLR) begin
         h_err_d = 1'b0;
         v_err_d = 1'b0;
      end
      if (h_new) h_err_d = 1'b1;
      if (v_new) v_err_d = 1'b1;
   end

   // Lock FSM next state
   always_comb begin
      state_d = state_q;
      if (PIX_CE) begin
         case (state_q)
            ST_SEARCH: if (vs_fall) state_d = ST_ALIGN;
            ST_ALIGN: begin
               if (h_new || v_new) state_d = ST_SEARCH;
               else if (vs_fall)   state_d = ST_LOCKED;
            end
            ST_LOCKED: if (h_new || v_new) state_d = ST_SEARCH;
            default:   state_d = ST_SEARCH;
         endcase
      end
   end

   // Active-window coordinate output and capture at (CAP_X, CAP_Y)
   always_comb begin
      in_win      = (h_cnt_q >= H_START) && (h_cnt_q <= H_END) &&
                    (v_cnt_q >= V_START) && (v_cnt_q <= V_END);
      pix_x_d     = pix_x_q;
      pix_y_d     = pix_y_q;
      pix_valid_d = pix_valid_q;
      pix_rgb_d   = pix_rgb_q;
      cap_rgb_d   = cap_rgb_q;
      cap_valid_d = 1'b0;
      if (PIX_CE) begin
         pix_valid_d = in_win;
         if (in_win) begin
            pix_x_d   = h_cnt_q - H_START;
            pix_y_d   = v_cnt_q - V_START;
            pix_rgb_d = rgb_dly_q;
         end
         if (pix_valid_q && (pix_x_q == CAP_X) && (pix_y_q == CAP_Y)) begin
            cap_rgb_d   = pix_rgb_q;
            cap_valid_d = 1'b1;
         end
      end
   end

   // State registers; sync history resets idle-high
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q       <= ST_SEARCH;
         hs_q          <= 1'b1;
         hs_prev_q     <= 1'b1;
         vs_q          <= 1'b1;
         vs_prev_q     <= 1'b1;
         rgb_q         <= '0;
         rgb_dly_q     <= '0;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         line_len_q    <= '0;
         frame_lines_q <= '0;
         frame_done_q  <= 1'b0;
         h_err_q       <= 1'b0;
         v_err_q       <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         pix_valid_q   <= 1'b0;
         pix_rgb_q     <= '0;
         cap_rgb_q     <= '0;
         cap_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         hs_q          <= hs_d;
         hs_prev_q     <= hs_prev_d;
         vs_q          <= vs_d;
         vs_prev_q     <= vs_prev_d;
         rgb_q         <= rgb_d;
         rgb_dly_q     <= rgb_dly_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         line_len_q    <= line_len_d;
         frame_lines_q <= frame_lines_d;
         frame_done_q  <= frame_done_d;
         h_err_q       <= h_err_d;
         v_err_q       <= v_err_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         pix_valid_q   <= pix_valid_d;
         pix_rgb_q     <= pix_rgb_d;
         cap_rgb_q     <= cap_rgb_d;
         cap_valid_q   <= cap_valid_d;
      end
   end

   assign PIX_X       = pix_x_q;
   assign PIX_Y       = pix_y_q;
   assign PIX_VALID   = pix_valid_q;
   assign PIX_RGB     = pix_rgb_q;
   assign LINE_LEN    = line_len_q;
   assign FRAME_LINES = frame_lines_q;
   assign FRAME_DONE  = frame_done_q;
   assign LOCKED      = (state_q == ST_LOCKED);
   assign H_ERR       = h_err_q;
   assign V_ERR       = v_err_q;
   assign CAP_RGB     = cap_rgb_q;
   assign CAP_VALID   = cap_valid_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: drives a reduced-geometry VGA stream with random colour
// and compares the monitor outputs against a coordinate-level reference model.
module tb_vga_sync_monitor;

   localparam int HS = 4;
   localparam int HB = 3;
   localparam int HA = 16;
   localparam int HT = 28;
   localparam int VS = 2;
   localparam int VB = 3;
   localparam int VA = 8;
   localparam int VT = 16;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b1;
   logic        PIX_CE = 1'b0;
   logic        VGA_HSYNC = 1'b1;
   logic        VGA_VSYNC = 1'b1;
   logic [3:0]  VGA_RED = '0;
   logic [3:0]  VGA_GREEN = '0;
   logic [3:0]  VGA_BLUE = '0;
   logic [10:0] CAP_X = '0;
   logic [10:0] CAP_Y = '0;
   logic        ERR_CLR = 1'b0;
   logic [10:0] PIX_X, PIX_Y, LINE_LEN, FRAME_LINES;
   logic        PIX_VALID, FRAME_DONE, LOCKED, H_ERR, V_ERR, CAP_VALID;
   logic [11:0] PIX_RGB, CAP_RGB;

   vga_sync_monitor #(
      .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_TOTAL(HT),
      .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_TOTAL(VT)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .PIX_CE(PIX_CE),
      .VGA_HSYNC(VGA_HSYNC), .VGA_VSYNC(VGA_VSYNC),
      .VGA_RED(VGA_RED), .VGA_GREEN(VGA_GREEN), .VGA_BLUE(VGA_BLUE),
      .CAP_X(CAP_X), .CAP_Y(CAP_Y), .ERR_CLR(ERR_CLR),
      .PIX_X(PIX_X), .PIX_Y(PIX_Y), .PIX_VALID(PIX_VALID), .PIX_RGB(PIX_RGB),
      .LINE_LEN(LINE_LEN), .FRAME_LINES(FRAME_LINES), .FRAME_DONE(FRAME_DONE),
      .LOCKED(LOCKED), .H_ERR(H_ERR), .V_ERR(V_ERR),
      .CAP_RGB(CAP_RGB), .CAP_VALID(CAP_VALID)
   );

   always #5 CLK = ~CLK;

   int          checks = 0;
   int          failures = 0;
   int          ce_div = 1;
   int          fd_cnt = 0;
   int          cap_cnt = 0;
   int          exp_fd = 0;
   int          exp_cap = 0;
   logic [11:0] exp_cap_rgb = '0;
   // expected {valid, x, y, rgb} for the last three pixel samples, plus held value
   logic [34:0] d0 = '0, d1 = '0, d2 = '0, last = '0;

   always @(negedge CLK) begin
      if (FRAME_DONE) fd_cnt++;
      if (CAP_VALID)  cap_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      PIX_CE = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge CLK); #1;
      end
   endtask

   task automatic clr_pulse();
      PIX_CE  = 1'b0;
      ERR_CLR = 1'b1;
      @(posedge CLK); #1;
      ERR_CLR = 1'b0;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      #2;
      chk("reset_pix", {PIX_VALID, PIX_X, PIX_Y, PIX_RGB}, '0);
      chk("reset_status", {LINE_LEN, FRAME_LINES, FRAME_DONE, LOCKED, H_ERR, V_ERR,
                           CAP_RGB, CAP_VALID}, '0);
      @(posedge CLK); #1;
      RST_N = 1'b1;
      d0 = '0; d1 = '0; d2 = '0; last = '0;
   endtask

   // One pixel sample; output expected two pixel-enables later
   task automatic px(input logic hs, input logic vs, input logic [11:0] c,
                     input logic act, input int x, input int y);
      logic [34:0] t;
      VGA_HSYNC = hs;
      VGA_VSYNC = vs;
      {VGA_RED, VGA_GREEN, VGA_BLUE} = c;
      PIX_CE = 1'b1;
      if (act) t = {1'b1, 11'(x), 11'(y), c};
      else     t = {1'b0, last[33:0]};
      last = t;
      if (act && x == int'(CAP_X) && y == int'(CAP_Y)) begin
         exp_cap++;
         exp_cap_rgb = c;
      end
      @(posedge CLK); #1;
      d2 = d1; d1 = d0; d0 = t;
      chk("pix", {PIX_VALID, PIX_X, PIX_Y, PIX_RGB}, {29'd0, d2});
      if (ce_div == 2) begin
         PIX_CE = 1'b0;
         @(posedge CLK); #1;
      end
   endtask

   // mode 0: random colour; mode 1: 12'hABC only at the capture point
   task automatic run_frame(input int vs_lines, input int stretch, input int mode, input int nlines);
      int len, x, y;
      logic act;
      logic [11:0] c;
      for (int ln = 0; ln < nlines; ln++) begin
         len = (ln == stretch) ? HT + 1 : HT;
         if (ln == 0) exp_fd++;
         for (int hp = 0; hp < len; hp++) begin
            act = (hp >= HS + HB) && (hp < HS + HB + HA) && (ln >= VS + VB) && (ln < VS + VB + VA);
            x = hp - (HS + HB);
            y = ln - (VS + VB);
            if (mode == 1) c = (act && x == int'(CAP_X) && y == int'(CAP_Y)) ? 12'hABC : 12'h000;
            else           c = 12'($urandom);
            px(hp >= HS, ln >= vs_lines, c, act, x, y);
         end
      end
   endtask

   initial begin
      CAP_X = 11'($urandom_range(HA - 1));
      CAP_Y = 11'($urandom_range(VA - 1));
      #2;
      do_reset();

      // clean frames: align on the first vsync fall, lock on the second
      run_frame(VS, -1, 0, VT);
      chk("align_not_locked", LOCKED, 1'b0);
      run_frame(VS, -1, 0, VT);
      idle(3);
      chk("locked", LOCKED, 1'b1);
      chk("line_len", LINE_LEN, 11'(HT));
      chk("frame_lines", FRAME_LINES, 11'(VT));
      chk("errs_clean", {H_ERR, V_ERR}, 2'b00);
      chk("frame_done_cnt", fd_cnt, exp_fd);

      // one stretched line breaks lock
      run_frame(VS, 6, 0, VT);
      idle(3);
      chk("stretch_h_err", H_ERR, 1'b1);
      chk("stretch_unlock", LOCKED, 1'b0);
      clr_pulse();
      chk("h_err_cleared", H_ERR, 1'b0);
      run_frame(VS, -1, 0, VT);
      run_frame(VS, -1, 0, VT);
      idle(3);
      chk("relock_after_stretch", {LOCKED, H_ERR, V_ERR}, 3'b100);

      // missing hsync saturates the line counter
      for (int i = 0; i < 2100; i++) px(1'b1, 1'b1, 12'($urandom), 1'b0, 0, 0);
      idle(3);
      chk("sat_h_err", {LOCKED, H_ERR}, 2'b01);
      clr_pulse();
      run_frame(VS, -1, 0, VT);
      run_frame(VS, -1, 0, VT);
      idle(3);
      chk("relock_after_sat", {LOCKED, H_ERR, V_ERR}, 3'b100);

      // vsync held low one line too long
      run_frame(3, -1, 0, VT);
      idle(3);
      chk("long_vsync_v_err", {LOCKED, H_ERR, V_ERR}, 3'b001);
      chk("frame_done_cnt_err", fd_cnt, exp_fd);
      clr_pulse();
      chk("v_err_cleared", V_ERR, 1'b0);
      run_frame(VS, -1, 0, VT);
      run_frame(VS, -1, 0, VT);
      idle(3);
      chk("relock_after_vsync", {LOCKED, V_ERR}, 2'b10);

      // capture point
      run_frame(VS, -1, 1, VT);
      idle(4);
      chk("cap_rgb_abc", CAP_RGB, exp_cap_rgb);
      chk("cap_count", cap_cnt, exp_cap);
      CAP_X = 11'(HA);
      run_frame(VS, -1, 0, VT);
      idle(4);
      chk("cap_out_of_range", cap_cnt, exp_cap);
      CAP_X = 11'($urandom_range(HA - 1));
      CAP_Y = 11'($urandom_range(VA - 1));
      run_frame(VS, -1, 0, VT);
      idle(4);
      chk("cap_rgb_rand", CAP_RGB, exp_cap_rgb);
      chk("cap_count_rand", cap_cnt, exp_cap);

      // half-rate pixel enable from a fresh reset
      do_reset();
      ce_div = 2;
      run_frame(VS, -1, 0, VT);
      chk("ce2_align", LOCKED, 1'b0);
      run_frame(VS, -1, 0, VT);
      idle(3);
      chk("ce2_locked", LOCKED, 1'b1);
      chk("ce2_line_len", LINE_LEN, 11'(HT));
      chk("ce2_frame_lines", FRAME_LINES, 11'(VT));
      chk("ce2_errs", {H_ERR, V_ERR}, 2'b00);
      chk("ce2_frame_done_cnt", fd_cnt, exp_fd);

      // reset mid-frame, then relock at full rate
      run_frame(VS, -1, 0, 8);
      do_reset();
      ce_div = 1;
      run_frame(VS, -1, 0, VT);
      run_frame(VS, -1, 0, VT);
      idle(3);
      chk("relock_after_reset", {LOCKED, H_ERR, V_ERR}, 3'b100);
      chk("frame_lines_after_reset", FRAME_LINES, 11'(VT));
      chk("frame_done_final", fd_cnt, exp_fd);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
